// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive framer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO, 8-bit wide, power-of-two depth.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_wr_s;
    logic          do_rd_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign do_rd_s = rd_en & ~empty;
    assign do_wr_s = wr_en & (~full | do_rd_s);
    assign rd_data = empty ? 8'h00 : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronizer, oversampled frame FSM, sticky error flags, receive FIFO.
// Optional macro UART_RX_MAJORITY_EN selects 3-sample majority voting per bit.
module uart_rx_framer
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx_in,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic          sync1_r;
    logic          sync2_r;
    rx_state_t     state_r,    state_n;
    logic [TW-1:0] tick_cnt_r, tick_cnt_n;
    logic [2:0]    bit_cnt_r,  bit_cnt_n;
    logic [7:0]    shift_r,    shift_n;
    logic          stop_bad_r, stop_bad_n;
    logic          push_r,     push_n;
    logic          frame_err_r;
    logic          parity_err_r;
    logic          overrun_r;
    logic          rx_busy_r;
    logic          set_fe_s;
    logic          set_pe_s;
    logic          bit_val_s;
    logic          par_calc_s;
    logic          exp_par_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Keeps the two previous tick samples so the decision tick sees mid-1, mid and mid+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= 2'b11;
        end else if (baud_tick) begin
            hist_r <= {hist_r[0], sync2_r};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign bit_val_s = majority3(hist_r[1], hist_r[0], sync2_r);
`else
    assign bit_val_s = sync2_r;
`endif

    assign par_calc_s = ^shift_r[DATA_BITS-1:0];
    assign exp_par_s  = (PARITY == PAR_ODD) ? ~par_calc_s : par_calc_s;

    // Frame FSM next-state, counters and error-set strobes; everything advances only on baud_tick.
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        stop_bad_n = stop_bad_r;
        push_n     = 1'b0;
        set_fe_s   = 1'b0;
        set_pe_s   = 1'b0;
        if (baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!sync2_r) begin
                        state_n    = ST_START;
                        tick_cnt_n = {TW{1'b0}};
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_cnt_r == START_DEC) begin
                        if (bit_val_s) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n    = ST_DATA;
                            tick_cnt_n = {TW{1'b0}};
                            bit_cnt_n  = 3'd0;
                            shift_n    = 8'h00;
                            stop_bad_n = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_n         = {TW{1'b0}};
                        shift_n[bit_cnt_r] = bit_val_s;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_n = 3'd0;
                            state_n   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_n = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_n = {TW{1'b0}};
                        set_pe_s   = (bit_val_s != exp_par_s);
                        state_n    = ST_STOP;
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_n = {TW{1'b0}};
                        set_fe_s   = ~bit_val_s;
                        if (bit_cnt_r == STOP_LAST) begin
                            state_n   = ST_IDLE;
                            bit_cnt_n = 3'd0;
                            push_n    = ~stop_bad_r & bit_val_s;
                        end else begin
                            bit_cnt_n  = bit_cnt_r + 3'd1;
                            stop_bad_n = stop_bad_r | ~bit_val_s;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    tick_cnt_n = {TW{1'b0}};
                    bit_cnt_n  = 3'd0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM state, counters, shift register and the registered push strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            stop_bad_r <= 1'b0;
            push_r     <= 1'b0;
            rx_busy_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            stop_bad_r <= stop_bad_n;
            push_r     <= push_n;
            rx_busy_r  <= (state_n != ST_IDLE);
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= set_fe_s ? 1'b1 : (clr_err ? 1'b0 : frame_err_r);
            parity_err_r <= set_pe_s ? 1'b1 : (clr_err ? 1'b0 : parity_err_r);
            overrun_r    <= (push_r & fifo_full_s & ~rd_en) ? 1'b1 :
                            (clr_err ? 1'b0 : overrun_r);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_r),
        .wr_data (shift_r),
        .rd_en   (rd_en),
        .rd_data (rx_data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign rx_valid   = ~fifo_empty_s;
    assign rx_busy    = rx_busy_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: an 8N1 instance and a 7E1 instance share the serial line.
module tb_uart_rx_framer;

    localparam int OS = 16;

    logic       clk;
    logic       reset;
    logic       baud_tick;
    logic       rx_in;
    logic       clr_err;
    logic       rd_en_a;
    logic       rd_en_b;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_busy, a_fe, a_pe, a_ov;
    logic       b_valid, b_busy, b_fe, b_pe, b_ov;

    int         checks;
    int         failures;
    logic [7:0] sb [$];

    uart_rx_framer dut_a (
        .clk (clk), .reset (reset), .baud_tick (baud_tick), .rx_in (rx_in),
        .rd_en (rd_en_a), .clr_err (clr_err), .rx_data (a_data), .rx_valid (a_valid),
        .rx_busy (a_busy), .frame_err (a_fe), .parity_err (a_pe), .overrun (a_ov)
    );

    uart_rx_framer #(.DATA_BITS (7), .PARITY (1)) dut_b (
        .clk (clk), .reset (reset), .baud_tick (baud_tick), .rx_in (rx_in),
        .rd_en (rd_en_b), .clr_err (clr_err), .rx_data (b_data), .rx_valid (b_valid),
        .rx_busy (b_busy), .frame_err (b_fe), .parity_err (b_pe), .overrun (b_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One oversample period: line value v, baud_tick pulse on the 4th clock.
    task automatic tick(input logic v);
        rx_in     = v;
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        for (int k = 0; k < OS; k++) begin
            tick((glitch && k == OS / 2) ? ~v : v);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1);
    endtask

    // par_mode: 0 none, 1 correct even parity, 2 forced parity bit par_v.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par_mode,
                              input logic par_v, input logic stop_v, input int glitch_bit);
        logic p;
        p = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i], i == glitch_bit);
            p = p ^ d[i];
        end
        if (par_mode == 1) send_bit(p, 1'b0);
        if (par_mode == 2) send_bit(par_v, 1'b0);
        send_bit(stop_v, 1'b0);
        idle(2 * OS);
    endtask

    task automatic pop_check(input int sel, input string tag);
        logic [7:0] exp;
        exp = sb.pop_front();
        if (sel == 0) begin
            check_eq({tag, "_valid"}, {7'd0, a_valid}, 8'd1);
            check_eq({tag, "_data"}, a_data, exp);
            rd_en_a = 1'b1;
        end else begin
            check_eq({tag, "_valid"}, {7'd0, b_valid}, 8'd1);
            check_eq({tag, "_data"}, b_data, exp);
            rd_en_b = 1'b1;
        end
        @(negedge clk);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rx_in = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; rx_in = 1'b1; baud_tick = 1'b0; clr_err = 1'b0;
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {7'd0, a_valid}, 8'd0);
        check_eq("rst_data", a_data, 8'h00);
        check_eq("rst_busy", {7'd0, a_busy}, 8'd0);
        check_eq("rst_flags", {5'd0, a_fe, a_pe, a_ov}, 8'd0);
        reset = 1'b0;
        idle(4);

        // Clean 8N1 frame.
        send_frame(8'h55, 8, 0, 1'b0, 1'b1, -1);
        sb.push_back(8'h55);
        check_eq("t1_flags", {5'd0, a_fe, a_pe, a_ov}, 8'd0);
        pop_check(0, "t1");
        check_eq("t1_empty", {7'd0, a_valid}, 8'd0);

        // Bad stop bit: not stored, frame_err until cleared.
        send_frame(8'hA3, 8, 0, 1'b0, 1'b0, -1);
        check_eq("t2_fe", {7'd0, a_fe}, 8'd1);
        check_eq("t2_valid", {7'd0, a_valid}, 8'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("t2_fe_clr", {7'd0, a_fe}, 8'd0);

        // Five frames into a 4-deep FIFO without reads.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 8, 0, 1'b0, 1'b1, -1);
            if (i <= 4) sb.push_back(8'(i));
        end
        check_eq("t3_ov", {7'd0, a_ov}, 8'd1);
        check_eq("t3_fe", {7'd0, a_fe}, 8'd0);
        for (int i = 0; i < 4; i++) pop_check(0, "t3");
        check_eq("t3_empty", {7'd0, a_valid}, 8'd0);

        // False start: four low ticks.
        tick(1'b0);
        check_eq("t4_busy", {7'd0, a_busy}, 8'd1);
        for (int k = 0; k < 3; k++) tick(1'b0);
        idle(2 * OS);
        check_eq("t4_idle", {7'd0, a_busy}, 8'd0);
        check_eq("t4_valid", {7'd0, a_valid}, 8'd0);
        check_eq("t4_fe", {7'd0, a_fe}, 8'd0);

        // Reset in the middle of data bit 3; overrun is still set from before.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < OS / 2; k++) tick(1'b1);
        check_eq("t5_busy_pre", {7'd0, a_busy}, 8'd1);
        rx_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_busy", {7'd0, a_busy}, 8'd0);
        check_eq("t5_rst_valid", {7'd0, a_valid}, 8'd0);
        check_eq("t5_rst_data", a_data, 8'h00);
        check_eq("t5_rst_flags", {5'd0, a_fe, a_pe, a_ov}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(OS);
        send_frame(8'hC3, 8, 0, 1'b0, 1'b1, -1);
        sb.push_back(8'hC3);
        pop_check(0, "t5");

        // 7E1 instance: good parity then wrong parity.
        pulse_reset();
        idle(4);
        send_frame(8'h25, 7, 1, 1'b0, 1'b1, -1);
        sb.push_back(8'h25);
        check_eq("t6_pe_ok", {7'd0, b_pe}, 8'd0);
        pop_check(1, "t6a");
        send_frame(8'h25, 7, 2, 1'b0, 1'b1, -1);
        sb.push_back(8'h25);
        check_eq("t6_pe", {7'd0, b_pe}, 8'd1);
        check_eq("t6_fe_ov", {6'd0, b_fe, b_ov}, 8'd0);
        check_eq("t6_busy", {7'd0, b_busy}, 8'd0);
        pop_check(1, "t6b");

        // One-tick glitch at the centre of data bit 2 of 0x00.
        pulse_reset();
        idle(4);
        send_frame(8'h00, 8, 0, 1'b0, 1'b1, 2);
`ifdef UART_RX_MAJORITY_EN
        sb.push_back(8'h00);
`else
        sb.push_back(8'h04);
`endif
        check_eq("t7_fe", {7'd0, a_fe}, 8'd0);
        pop_check(0, "t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8; frame data bits, legal 5..8.
REQ-002 SHALL have parameter PARITY, default 0; 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1; legal 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16; baud_tick pulses per bit, legal even values 8..64.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4; receive FIFO entries, power of two, 2..64.
REQ-006 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port baud_tick  input  1  one-clk oversample strobe.
REQ-009 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rd_en  input  1  pop FIFO head.
REQ-011 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-012 SHALL have port rx_data  output  8  FIFO head, show-ahead, right-justified, upper bits zero when DATA_BITS<8.
REQ-013 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port rx_busy  output  1  state not IDLE.
REQ-015 SHALL have ports frame_err, parity_err, overrun  output  1 each  sticky error flags.

Function
REQ-016 rx_in SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP; tick counter width clog2(OVERSAMPLE), bit counter width 3.
REQ-018 IDLE -> START on synchronized rx low; tick counter cleared.
REQ-019 START: at tick OVERSAMPLE/2-1, sampled high -> IDLE (false start, nothing pushed); low -> DATA, counters cleared.
REQ-020 DATA: sample every OVERSAMPLE ticks, LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: sampled bit SHALL be checked against XOR of data bits (even) or its inverse (odd); mismatch sets parity_err.
REQ-022 STOP: each stop bit sampled mid-bit; any low sample sets frame_err; return to IDLE right after last stop-bit sample.
REQ-023 Frame with framing error SHALL NOT be pushed; frame with only parity error SHALL be pushed.
REQ-024 Push SHALL occur on clk after last stop-bit sample; rx_valid rises 1 clk later when FIFO was empty.
REQ-025 Push while full and no simultaneous pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-026 Simultaneous push and pop when full: both performed, no overrun; rd_en while empty ignored.
REQ-027 clr_err clears all three flags; same-cycle set wins over clear.
REQ-028 baud_tick absent: state and counters hold.

Reset
REQ-029 Reset SHALL force IDLE, counters 0, FIFO empty, rx_data 0, rx_valid 0, rx_busy 0, all error flags 0, synchronizer 1, including mid-frame; partial frame discarded.

Configuration
REQ-030 With UART_RX_MAJORITY_EN defined, each bit value (start, data, parity, stop) SHALL be majority of samples at ticks mid-1, mid, mid+1, decided at mid+1; without it, single sample at mid.

Structure
REQ-031 Package uart_rx_pkg SHALL hold the state enum and PARITY constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-032 FIFO SHALL be sub-module uart_rx_fifo (parameter DEPTH, 8-bit, show-ahead, full/empty outputs).

Verification
REQ-033 8N1, OVERSAMPLE 16, send 0x55 -> rx_valid, rx_data 0x55, no flags.
REQ-034 DATA_BITS 7, PARITY even, send 0x25 with parity bit 0 (wrong) -> rx_data 0x25, parity_err 1.
REQ-035 8N1, stop bit 0 on 0xA3 -> frame_err 1, rx_valid stays 0; clr_err -> frame_err 0.
REQ-036 FIFO_DEPTH 4, send 0x01..0x05 without reads -> overrun 1; pops yield 0x01..0x04 then rx_valid 0.
REQ-037 rx_in low 4 ticks then high -> rx_busy pulses, returns IDLE, nothing pushed; reset at DATA bit 3 -> all outputs reset values, next frame 0xC3 received correctly.
REQ-038 With UART_RX_MAJORITY_EN, one-tick inverted glitch at mid of data bit 2 of 0x00 -> rx_data 0x00; without macro -> 0x04.
